wb16_bridge_master: RTL and testbench
=====================================

# wb16_bridge_master

Wishbone initiator that turns a 32-bit client request into one or two 16-bit Wishbone classic cycles. It sits between the CPU-side 32-bit port and the 16-bit SoC bus that carries the boot ROM, RAM and peripherals. Word data is assembled big-endian: the upper half lives at the lower address. The block also watches for a missing slave acknowledge and reports an error if one never arrives.

## Interface
- TIMEOUT, 255: cycles to wait for `wb_ack_i` per phase before aborting; 1..65535.
- clk_i  input  1  sole clock, rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req_i  input  1  client request strobe; sampled only in IDLE.
- we_i  input  1  client write enable.
- adr_i  input  32  client byte address; bits [1:0] ignored (forced 0).
- dat_i  input  32  client write data.
- sel_i  input  4  client byte enables; [3:2] select the upper half, [1:0] the lower half.
- tga_i  input  1  client address tag, forwarded unchanged.
- dat_o  output  32  read data; valid while `ack_o` is 1.
- ack_o  output  1  one-cycle completion pulse.
- err_o  output  1  one-cycle timeout pulse; mutually exclusive with `ack_o`.
- wb_adr_o  output  32  bus address.
- wb_dat_o  output  16  bus write data.
- wb_dat_i  input  16  bus read data.
- wb_we_o, wb_tga_o, wb_stb_o, wb_cyc_o  output  1 each  bus controls.
- wb_sel_o  output  2  bus byte enables.
- wb_ack_i  input  1  bus acknowledge.

## Operation
- **States:** IDLE, HI, GAP, LO, DONE.
- **Request capture:** in IDLE, `req_i`=1 latches `we_i`, {`adr_i`[31:2],2'b00}, `dat_i`, `sel_i` and `tga_i`. `req_i` is ignored in every other state.
- **State selection from IDLE:**
  - `sel_i`[3:2]≠0 → HI.
  - `sel_i`[3:2]=0 and `sel_i`[1:0]≠0 → LO.
  - `sel_i`=0 → DONE, with no bus activity.
- **HI phase:**
  - `wb_adr_o` = base address.
  - `wb_sel_o` = `sel`[3:2].
  - `wb_dat_o` = `dat`[31:16].
- **LO phase:**
  - `wb_adr_o` = base + 2.
  - `wb_sel_o` = `sel`[1:0].
  - `wb_dat_o` = `dat`[15:0].
- **Bus controls per state:**
  - `wb_stb_o`=1 in HI and LO only.
  - `wb_cyc_o`=1 from the first bus phase until leaving the last one, including GAP.
  - `wb_we_o` and `wb_tga_o` = latched values while `wb_cyc_o`=1, otherwise 0.
- **HI exit on `wb_ack_i`=1:**
  - On a read, capture `wb_dat_i` into `dat_o`[31:16].
  - Go to GAP if `sel`[1:0]≠0, else DONE.
- **GAP:** lasts exactly one cycle, with `wb_stb_o`=0, then goes to LO.
  - GAP exists because slaves register their ack from stb&cyc, so an ack arriving in the cycle after stb falls is stale.
  - `wb_ack_i` is ignored whenever `wb_stb_o`=0.
- **LO exit on `wb_ack_i`=1:** on a read, capture `wb_dat_i` into `dat_o`[15:0], then go to DONE.
- **Skipped halves and writes:** a skipped half reads as 0. On writes, `dat_o` = 0.
- **DONE:** `ack_o`=1 for one cycle, then IDLE.
- **Timeout counter:**
  - Width is 16 bits.
  - Cleared on entry to HI and to LO; increments every cycle in HI or LO.
  - Reaching TIMEOUT without an ack drops `wb_stb_o` and `wb_cyc_o` on the next edge.
  - The block then pulses `err_o` for one cycle, pulses no `ack_o`, and returns to IDLE with `dat_o` = 0.
- **Ack on the timeout cycle:** an ack arriving in the same cycle the count reaches TIMEOUT wins; the phase completes normally.
- **Reset:** `rst_i`=1 at any point, including mid-transaction, aborts the transaction at the next edge. It produces no `ack_o` and no `err_o`.

## Timing
- **Reset values:** every output is 0 after a reset edge, and the state is IDLE.
- **Cycle numbering:** E0 is the edge that samples `req_i`. Cycle n is the cycle following edge En.
- **Full 32-bit access to a one-wait-state slave** (ack one cycle after stb):
  - HI: `wb_stb_o`=1 in cycles 1–2.
  - GAP: cycle 3.
  - LO: `wb_stb_o`=1 in cycles 4–5.
  - `ack_o` in cycle 6.
  - `wb_cyc_o`=1 in cycles 1–5.
- **Single-half access:** `wb_stb_o` in cycles 1–2, `ack_o` in cycle 3.
- **`sel_i`=0:** `ack_o` in cycle 1.
- **Back-to-back requests:** a new request is accepted in the `ack_o` cycle + 1 at the earliest, i.e. when IDLE is re-entered.
- **Zero-wait slave** (combinational ack): a phase lasts 1 cycle; a full access ends with `ack_o` in cycle 4.
- **Timeout latency** with no ack ever: `wb_stb_o` is high for TIMEOUT+1 cycles, and `err_o` occurs the cycle after stb drops.

## Test plan
- **Full read:** slave returns 0x1234 at 0x100 and 0x5678 at 0x102. Request read adr=0x103, sel=0xF → `wb_adr_o` = 0x100 then 0x102, `dat_o` = 0x12345678, `ack_o` in cycle 6, stb low in cycle 3.
- **Full write:** write adr=0x200, dat=0xDEADBEEF, sel=0xF → bus writes 0xDEAD@0x200 with sel=2'b11, then 0xBEEF@0x202, then one `ack_o`.
- **Partial and empty sel:** sel=0x1 read → only LO phase at base+2 with `wb_sel_o`=2'b01, `dat_o`[31:16]=0. sel=0x0 → no stb, `ack_o` in cycle 1.
- **Stale-ack immunity:** slave holds `wb_ack_i`=1 in the GAP cycle → no premature LO completion, LO data still captured from its own ack.
- **Timeout:** TIMEOUT=4, slave never acks → stb high 5 cycles, `err_o` single pulse, no `ack_o`; next request then completes normally.
- **Reset mid-op:** assert `rst_i` in cycle 4 of a full read → all outputs 0 at the next edge, no `ack_o`/`err_o`; a request issued after reset completes with correct data.

Source files
------------

// File: rtl/wb16_bridge_master.sv
// Wishbone initiator: splits a 32-bit client access into one or two big-endian 16-bit
// classic cycles (upper half at the lower address), with a per-phase ack timeout.
module wb16_bridge_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    input  logic [3:0]  sel_i,
    input  logic        tga_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        err_o,
    output logic [31:0] wb_adr_o,
    output logic [15:0] wb_dat_o,
    input  logic [15:0] wb_dat_i,
    output logic        wb_we_o,
    output logic        wb_tga_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    output logic [1:0]  wb_sel_o,
    input  logic        wb_ack_i
);
    typedef enum logic [2:0] {StIdle, StHi, StGap, StLo, StDone} state_e;

    localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);

    state_e      state_q;
    logic [31:0] adr_lo_q;
    logic [15:0] dat_lo_q;
    logic [1:0]  sel_lo_q;
    logic [15:0] cnt_q;

    logic [31:0] base_in;
    logic        phase_ack;
    logic        phase_expired;

    assign base_in       = adr_i & 32'hFFFF_FFFC;
    // Acks seen while stb is low are stale registered acks from the previous phase.
    assign phase_ack     = wb_stb_o & wb_ack_i;
    assign phase_expired = (cnt_q == TimeoutCnt);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            adr_lo_q <= '0;
            dat_lo_q <= '0;
            sel_lo_q <= '0;
            cnt_q    <= '0;
            dat_o    <= '0;
            ack_o    <= 1'b0;
            err_o    <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_sel_o <= '0;
            wb_we_o  <= 1'b0;
            wb_tga_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_i) begin
                        adr_lo_q <= base_in + 32'd2;
                        dat_lo_q <= dat_i[15:0];
                        sel_lo_q <= sel_i[1:0];
                        cnt_q    <= '0;
                        dat_o    <= '0;
                        if (sel_i[3:2] != 2'b00) begin
                            state_q  <= StHi;
                            wb_adr_o <= base_in;
                            wb_sel_o <= sel_i[3:2];
                            wb_dat_o <= dat_i[31:16];
                            wb_we_o  <= we_i;
                            wb_tga_o <= tga_i;
                            wb_stb_o <= 1'b1;
                            wb_cyc_o <= 1'b1;
                        end else if (sel_i[1:0] != 2'b00) begin
                            state_q  <= StLo;
                            wb_adr_o <= base_in + 32'd2;
                            wb_sel_o <= sel_i[1:0];
                            wb_dat_o <= dat_i[15:0];
                            wb_we_o  <= we_i;
                            wb_tga_o <= tga_i;
                            wb_stb_o <= 1'b1;
                            wb_cyc_o <= 1'b1;
                        end else begin
                            state_q <= StDone;
                            ack_o   <= 1'b1;
                        end
                    end
                end
                StHi: begin
                    if (phase_ack) begin
                        if (!wb_we_o) begin
                            dat_o[31:16] <= wb_dat_i;
                        end
                        if (sel_lo_q != 2'b00) begin
                            state_q  <= StGap;
                            wb_stb_o <= 1'b0;
                        end else begin
                            state_q  <= StDone;
                            ack_o    <= 1'b1;
                            wb_stb_o <= 1'b0;
                            wb_cyc_o <= 1'b0;
                            wb_we_o  <= 1'b0;
                            wb_tga_o <= 1'b0;
                        end
                    end else if (phase_expired) begin
                        state_q  <= StDone;
                        err_o    <= 1'b1;
                        dat_o    <= '0;
                        wb_stb_o <= 1'b0;
                        wb_cyc_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        wb_tga_o <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StGap: begin
                    state_q  <= StLo;
                    wb_adr_o <= adr_lo_q;
                    wb_sel_o <= sel_lo_q;
                    wb_dat_o <= dat_lo_q;
                    wb_stb_o <= 1'b1;
                    cnt_q    <= '0;
                end
                StLo: begin
                    if (phase_ack) begin
                        if (!wb_we_o) begin
                            dat_o[15:0] <= wb_dat_i;
                        end
                        state_q  <= StDone;
                        ack_o    <= 1'b1;
                        wb_stb_o <= 1'b0;
                        wb_cyc_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        wb_tga_o <= 1'b0;
                    end else if (phase_expired) begin
                        state_q  <= StDone;
                        err_o    <= 1'b1;
                        dat_o    <= '0;
                        wb_stb_o <= 1'b0;
                        wb_cyc_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        wb_tga_o <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    ack_err_excl: assert property (@(posedge clk_i) !(ack_o && err_o));
    stb_in_cyc:   assert property (@(posedge clk_i) wb_stb_o |-> wb_cyc_o);

endmodule

// File: tb/tb_wb16_bridge_master.sv
// Bench for wb16_bridge_master: per-transaction cycle traces built from a transaction-level
// model with a scripted slave, compared against the DUT every cycle.
module tb_wb16_bridge_master;
    localparam int TO    = 4;
    localparam int NEVER = 1000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [31:0] adr_i;
    logic [31:0] dat_i;
    logic [3:0]  sel_i;
    logic        tga_i;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        err_o;
    logic [31:0] wb_adr_o;
    logic [15:0] wb_dat_o;
    logic [15:0] wb_dat_i;
    logic        wb_we_o;
    logic        wb_tga_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic [1:0]  wb_sel_o;
    logic        wb_ack_i;

    always #5 clk_i = ~clk_i;

    wb16_bridge_master #(.TIMEOUT(TO)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req_i),
        .we_i     (we_i),
        .adr_i    (adr_i),
        .dat_i    (dat_i),
        .sel_i    (sel_i),
        .tga_i    (tga_i),
        .dat_o    (dat_o),
        .ack_o    (ack_o),
        .err_o    (err_o),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_we_o  (wb_we_o),
        .wb_tga_o (wb_tga_o),
        .wb_stb_o (wb_stb_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_sel_o (wb_sel_o),
        .wb_ack_i (wb_ack_i)
    );

    // One record per clock cycle: inputs to drive in that cycle and outputs expected in it.
    typedef struct {
        logic        rst, start, req, we, tga;
        logic [31:0] adr, dat;
        logic [3:0]  sel;
        logic        ack_in;
        logic [15:0] rd_in;
        logic        stb, cyc, we_o, tga_o, ack_o, err_o, chk_dat;
        logic [31:0] adr_o, dat_o;
        logic [1:0]  sel_o;
        logic [15:0] wdat_o;
    } rec_t;

    rec_t        exp_q[$];
    logic [15:0] mem [logic [31:0]];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc_cnt = 0;
    int          req_cyc, ack_cyc, err_cyc, ack_n, err_n, stb_n;
    logic [31:0] ack_dat;

    function automatic logic [15:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[7:0], ~a[15:8]};
    endfunction

    function automatic rec_t idle_rec();
        rec_t r;
        r = '{default: '0};
        r.ack_in = 1'($urandom_range(0, 1));
        r.rd_in  = 16'($urandom);
        return r;
    endfunction

    // Busy cycles carry request noise that the DUT must ignore.
    function automatic rec_t busy_rec();
        rec_t r;
        r = idle_rec();
        r.req = 1'($urandom_range(0, 1));
        r.we  = 1'($urandom_range(0, 1));
        r.tga = 1'($urandom_range(0, 1));
        r.adr = $urandom;
        r.dat = $urandom;
        r.sel = 4'($urandom);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc_cnt, act, want);
        end
    endtask

    // One bus phase; slave acks in phase cycle c (0 = same cycle), never if c > TO.
    task automatic add_phase(input logic we, input logic tga, input logic [31:0] a,
                             input logic [1:0] s, input logic [15:0] wd, input int c,
                             output bit ok, output logic [15:0] rd);
        rec_t        r;
        int          dur;
        logic [15:0] m;
        dur = (c <= TO) ? c + 1 : TO + 1;
        rd  = mem_rd(a);
        for (int i = 0; i < dur; i++) begin
            r = busy_rec();
            r.stb = 1'b1;  r.cyc = 1'b1;  r.we_o = we;  r.tga_o = tga;
            r.adr_o = a;   r.sel_o = s;   r.wdat_o = wd;
            r.ack_in = 1'(i == c);
            if (i == c) r.rd_in = rd;
            exp_q.push_back(r);
        end
        ok = (c <= TO);
        if (ok && we) begin
            m = rd;
            if (s[1]) m[15:8] = wd[15:8];
            if (s[0]) m[7:0] = wd[7:0];
            mem[a] = m;
        end
    endtask

    task automatic build_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input logic tga, input int c_hi,
                             input int c_lo, input bit gap_ack, input int n_idle,
                             output int ridx);
        rec_t        r;
        logic [31:0] base, res;
        logic [15:0] rdh, rdl;
        bit          ok;
        base = adr & ~32'h3;
        res  = '0;
        ok   = 1'b1;
        for (int i = 0; i < n_idle; i++) exp_q.push_back(idle_rec());
        ridx = exp_q.size();
        r = idle_rec();
        r.start = 1'b1;  r.req = 1'b1;  r.we = we;  r.adr = adr;
        r.dat = dat;     r.sel = sel;   r.tga = tga;
        exp_q.push_back(r);
        if (sel[3:2] != 2'b00) begin
            add_phase(we, tga, base, sel[3:2], dat[31:16], c_hi, ok, rdh);
            if (ok && !we) res[31:16] = rdh;
            if (ok && sel[1:0] != 2'b00) begin
                r = busy_rec();
                r.cyc = 1'b1;  r.we_o = we;  r.tga_o = tga;
                if (gap_ack) r.ack_in = 1'b1;
                exp_q.push_back(r);
            end
        end
        if (ok && sel[1:0] != 2'b00) begin
            add_phase(we, tga, base + 32'd2, sel[1:0], dat[15:0], c_lo, ok, rdl);
            if (ok && !we) res[15:0] = rdl;
        end
        r = busy_rec();
        r.chk_dat = 1'b1;
        if (ok) begin
            r.ack_o = 1'b1;
            r.dat_o = res;
        end else begin
            r.err_o = 1'b1;
            r.dat_o = '0;
        end
        exp_q.push_back(r);
    endtask

    // Single compare process: one record per cycle, sampled at the falling edge.
    task automatic drain();
        rec_t r;
        while (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            @(negedge clk_i);
            cyc_cnt++;
            if (r.start) begin
                req_cyc = cyc_cnt;  ack_n = 0;  err_n = 0;  stb_n = 0;
                ack_cyc = -1;       err_cyc = -1;
            end
            chk("stb", 32'(wb_stb_o), 32'(r.stb));
            chk("cyc", 32'(wb_cyc_o), 32'(r.cyc));
            chk("wb_we", 32'(wb_we_o), 32'(r.we_o));
            chk("wb_tga", 32'(wb_tga_o), 32'(r.tga_o));
            chk("ack", 32'(ack_o), 32'(r.ack_o));
            chk("err", 32'(err_o), 32'(r.err_o));
            if (r.stb) begin
                chk("wb_adr", wb_adr_o, r.adr_o);
                chk("wb_sel", 32'(wb_sel_o), 32'(r.sel_o));
                chk("wb_dat", 32'(wb_dat_o), 32'(r.wdat_o));
            end
            if (r.chk_dat) chk("dat_o", dat_o, r.dat_o);
            if (wb_stb_o === 1'b1) stb_n++;
            if (ack_o === 1'b1) begin
                ack_n++;
                ack_cyc = cyc_cnt;
                ack_dat = dat_o;
            end
            if (err_o === 1'b1) begin
                err_n++;
                err_cyc = cyc_cnt;
            end
            rst_i    = r.rst;
            req_i    = r.req;
            we_i     = r.we;
            adr_i    = r.adr;
            dat_i    = r.dat;
            sel_i    = r.sel;
            tga_i    = r.tga;
            wb_ack_i = r.ack_in;
            wb_dat_i = r.rd_in;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rec_t r;
        int   ridx;
        int   c_hi, c_lo;
        rst_i = 1'b1;  req_i = 1'b0;  we_i = 1'b0;  adr_i = '0;  dat_i = '0;
        sel_i = '0;    tga_i = 1'b0;  wb_ack_i = 1'b0;  wb_dat_i = '0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        r = idle_rec();
        r.chk_dat = 1'b1;
        exp_q.push_back(r);
        drain();

        // Full read, one-wait slave.
        mem[32'h100] = 16'h1234;
        mem[32'h102] = 16'h5678;
        build_txn(1'b0, 32'h103, 32'h0, 4'hF, 1'b0, 1, 1, 1'b0, 0, ridx);
        drain();
        chk("rd_ack_cycle", 32'(ack_cyc - req_cyc), 32'd6);
        chk("rd_data", ack_dat, 32'h1234_5678);
        chk("rd_stb_cycles", 32'(stb_n), 32'd4);

        // Full write, then read it back.
        build_txn(1'b1, 32'h200, 32'hDEAD_BEEF, 4'hF, 1'b1, 1, 1, 1'b0, 1, ridx);
        drain();
        chk("wr_ack_count", 32'(ack_n), 32'd1);
        chk("wr_dat_o", ack_dat, 32'h0);
        build_txn(1'b0, 32'h200, 32'h0, 4'hF, 1'b0, 0, 2, 1'b0, 1, ridx);
        drain();
        chk("wr_readback", ack_dat, 32'hDEAD_BEEF);

        // Low half only, then empty select.
        mem[32'h302] = 16'hC0DE;
        build_txn(1'b0, 32'h300, 32'h0, 4'h1, 1'b0, 1, 1, 1'b0, 0, ridx);
        drain();
        chk("lo_ack_cycle", 32'(ack_cyc - req_cyc), 32'd3);
        chk("lo_data", ack_dat, 32'h0000_C0DE);
        chk("lo_stb_cycles", 32'(stb_n), 32'd2);
        build_txn(1'b0, 32'h400, 32'h0, 4'h0, 1'b0, 1, 1, 1'b0, 0, ridx);
        drain();
        chk("sel0_ack_cycle", 32'(ack_cyc - req_cyc), 32'd1);
        chk("sel0_stb_cycles", 32'(stb_n), 32'd0);

        // Stale ack held high in the gap cycle.
        mem[32'h500] = 16'h1357;
        mem[32'h502] = 16'h2468;
        build_txn(1'b0, 32'h500, 32'h0, 4'hF, 1'b1, 1, 2, 1'b1, 0, ridx);
        drain();
        chk("stale_ack_cycle", 32'(ack_cyc - req_cyc), 32'd7);
        chk("stale_data", ack_dat, 32'h1357_2468);

        // Timeout in HI, then an immediate zero-wait request.
        build_txn(1'b0, 32'h600, 32'h0, 4'hF, 1'b0, NEVER, 0, 1'b0, 0, ridx);
        drain();
        chk("to_stb_cycles", 32'(stb_n), 32'd5);
        chk("to_err_cycle", 32'(err_cyc - req_cyc), 32'd6);
        chk("to_ack_count", 32'(ack_n), 32'd0);
        chk("to_err_count", 32'(err_n), 32'd1);
        build_txn(1'b0, 32'h100, 32'h0, 4'hF, 1'b0, 0, 0, 1'b0, 0, ridx);
        drain();
        chk("zw_ack_cycle", 32'(ack_cyc - req_cyc), 32'd4);
        chk("zw_data", ack_dat, 32'h1234_5678);

        // Ack on the timeout cycle wins; timeout in LO after a good HI.
        build_txn(1'b0, 32'h100, 32'h0, 4'hC, 1'b0, TO, 0, 1'b0, 1, ridx);
        drain();
        chk("edge_ack_cycle", 32'(ack_cyc - req_cyc), 32'd6);
        chk("edge_data", ack_dat, 32'h1234_0000);
        chk("edge_err_count", 32'(err_n), 32'd0);
        build_txn(1'b0, 32'h100, 32'h0, 4'hF, 1'b0, 1, NEVER, 1'b0, 1, ridx);
        drain();
        chk("lo_to_err_cycle", 32'(err_cyc - req_cyc), 32'd9);

        // Reset in cycle 4 of a full read.
        build_txn(1'b0, 32'h100, 32'h0, 4'hF, 1'b0, 1, 1, 1'b0, 1, ridx);
        while (exp_q.size() > ridx + 5) void'(exp_q.pop_back());
        r = exp_q[ridx + 4];
        r.rst = 1'b1;
        exp_q[ridx + 4] = r;
        r = idle_rec();
        r.chk_dat = 1'b1;
        exp_q.push_back(r);
        drain();
        chk("rst_ack_count", 32'(ack_n), 32'd0);
        chk("rst_err_count", 32'(err_n), 32'd0);
        build_txn(1'b0, 32'h500, 32'h0, 4'hF, 1'b0, 1, 1, 1'b0, 0, ridx);
        drain();
        chk("post_rst_data", ack_dat, 32'h1357_2468);

        // Randomized traffic over a small window so reads see earlier writes.
        for (int t = 0; t < 200; t++) begin
            c_hi = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, TO)) : NEVER;
            c_lo = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, TO)) : NEVER;
            build_txn(1'($urandom_range(0, 1)),
                      32'h1000 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3)),
                      $urandom,
                      ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom),
                      1'($urandom_range(0, 1)), c_hi, c_lo,
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), ridx);
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
